// File: rtl/iic_pkg.sv
// rtl/iic_pkg.sv - shared types and constants for the IIC memory master
// IIC_READ_EN adds the read-path states to the state enum.
package iic_pkg;

  localparam int   QUARTERS      = 4;
  localparam int   BITS_PER_BYTE = 8;
  localparam logic RW_WRITE      = 1'b0;
  localparam logic RW_READ       = 1'b1;
  localparam int   WRITE_SLOTS   = 29;
  localparam int   READ_SLOTS    = 39;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_DEV_W,
    ST_ACK_DEV,
    ST_ADDR,
    ST_ACK_ADDR,
    ST_WDATA,
    ST_ACK_DATA,
`ifdef IIC_READ_EN
    ST_RSTART,
    ST_DEV_R,
    ST_ACK_DEVR,
    ST_RDATA,
    ST_MNACK,
`endif
    ST_STOP
  } state_t;

  function automatic logic [7:0] dev_byte(input logic [6:0] dev, input logic rw_bit);
    return {dev, rw_bit};
  endfunction

endpackage

// File: rtl/iic_bit_timer.sv
// rtl/iic_bit_timer.sv - SCL divider and quarter counter for the IIC memory master
// One bit slot is QUARTERS quarters of CLK_DIV cycles each.
module iic_bit_timer
  import iic_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [1:0] quarter_o,
  output logic       q_first_o,
  output logic       q_end_o,
  output logic       slot_end_o
);

  logic [7:0] div_q, div_d;
  logic [1:0] quarter_q, quarter_d;
  logic       div_last;

  assign div_last = (div_q == 8'(CLK_DIV - 1));

  always_comb begin
    div_d     = div_q;
    quarter_d = quarter_q;
    if (clr_i) begin
      div_d     = '0;
      quarter_d = '0;
    end else if (en_i) begin
      if (div_last) begin
        div_d     = '0;
        quarter_d = quarter_q + 2'd1;
      end else begin
        div_d = div_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q     <= '0;
      quarter_q <= '0;
    end else begin
      div_q     <= div_d;
      quarter_q <= quarter_d;
    end
  end

  assign quarter_o  = quarter_q;
  assign q_first_o  = en_i && (div_q == 8'd0);
  assign q_end_o    = en_i && div_last;
  assign slot_end_o = q_end_o && (quarter_q == 2'(QUARTERS - 1));

endmodule

// File: rtl/iic_mem_master.sv
// rtl/iic_mem_master.sv - IIC initiator for single-byte memory write/read over sck/sda
// IIC_READ_EN compiles in the read path; without it every transaction is a write.
module iic_mem_master
  import iic_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       GCLK,
  input  logic       RESET,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] mem_addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic [7:0] rdata,
  output logic       sck,
  inout  wire        sda
);

  state_t     state_q;
  logic [6:0] dev_q;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic [7:0] shreg_q;
  logic [2:0] bit_cnt_q;
  logic       nack_flag_q;
  logic       sda_smp_q;
  logic       sda_oe_q;
  logic       sck_q;
  logic       busy_q;
  logic       done_q;
  logic       nack_q;

  logic [1:0] quarter;
  logic [1:0] quarter_nx;
  logic       q_first;
  logic       q_end;
  logic       slot_end;
  logic       accept;
  logic       q0_oe;
  state_t     ack_state;

  assign accept     = (state_q == ST_IDLE) && start;
  assign quarter_nx = quarter + {1'b0, q_end};

  iic_bit_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .clk_i     (GCLK),
    .rst_i     (RESET),
    .clr_i     (accept),
    .en_i      (busy_q),
    .quarter_o (quarter),
    .q_first_o (q_first),
    .q_end_o   (q_end),
    .slot_end_o(slot_end)
  );

  // SDA level for the Q0 update and the ACK slot that follows each byte.
  always_comb begin
    q0_oe     = 1'b0;
    ack_state = ST_STOP;
    case (state_q)
      ST_DEV_W: begin q0_oe = ~shreg_q[7]; ack_state = ST_ACK_DEV;  end
      ST_ADDR:  begin q0_oe = ~shreg_q[7]; ack_state = ST_ACK_ADDR; end
      ST_WDATA: begin q0_oe = ~shreg_q[7]; ack_state = ST_ACK_DATA; end
`ifdef IIC_READ_EN
      ST_DEV_R: begin q0_oe = ~shreg_q[7]; ack_state = ST_ACK_DEVR; end
      ST_RDATA: begin q0_oe = 1'b0;        ack_state = ST_MNACK;    end
`endif
      ST_STOP:  q0_oe = 1'b1;
      default:  q0_oe = 1'b0;
    endcase
  end

`ifdef IIC_READ_EN
  logic       rw_q;
  logic [7:0] rdata_q;

  always_ff @(posedge GCLK or posedge RESET) begin
    if (RESET) begin
      rw_q    <= RW_WRITE;
      rdata_q <= 8'h00;
    end else begin
      if (accept) rw_q <= rw;
      if ((state_q == ST_STOP) && slot_end && (rw_q == RW_READ) && !nack_flag_q)
        rdata_q <= shreg_q;
    end
  end

  assign rdata = rdata_q;
`else
  logic unused_rw;
  assign unused_rw = rw;
  assign rdata     = 8'h00;
`endif

  always_ff @(posedge GCLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      dev_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      nack_flag_q <= 1'b0;
      sda_smp_q   <= 1'b1;
      sda_oe_q    <= 1'b0;
      sck_q       <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      nack_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        sck_q    <= 1'b1;
        sda_oe_q <= 1'b0;
        if (start) begin
          state_q     <= ST_START;
          dev_q       <= dev_addr;
          addr_q      <= mem_addr;
          wdata_q     <= wdata;
          bit_cnt_q   <= '0;
          nack_flag_q <= 1'b0;
          nack_q      <= 1'b0;
          busy_q      <= 1'b1;
          sck_q       <= 1'b0;
        end
      end else begin
        sck_q <= quarter_nx[1];
        if (q_end && (quarter == 2'd2)) sda_smp_q <= sda;
        // SDA moves one cycle into Q0 so it never shares a cycle with an SCL edge.
        if (q_first && (quarter == 2'd0)) sda_oe_q <= q0_oe;
        if (q_first && (quarter == 2'd3)) begin
          if (state_q == ST_START) sda_oe_q <= 1'b1;
`ifdef IIC_READ_EN
          if (state_q == ST_RSTART) sda_oe_q <= 1'b1;
`endif
          if (state_q == ST_STOP) sda_oe_q <= 1'b0;
        end
        if (slot_end) begin
          case (state_q)
            ST_START: begin
              state_q <= ST_DEV_W;
              shreg_q <= dev_byte(dev_q, RW_WRITE);
            end
`ifdef IIC_READ_EN
            ST_DEV_W, ST_ADDR, ST_WDATA, ST_DEV_R, ST_RDATA: begin
`else
            ST_DEV_W, ST_ADDR, ST_WDATA: begin
`endif
              shreg_q   <= {shreg_q[6:0], sda_smp_q};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'(BITS_PER_BYTE - 1)) state_q <= ack_state;
            end
            ST_ACK_DEV: begin
              if (sda_smp_q) begin
                nack_flag_q <= 1'b1;
                state_q     <= ST_STOP;
              end else begin
                state_q <= ST_ADDR;
                shreg_q <= addr_q;
              end
            end
            ST_ACK_ADDR: begin
              if (sda_smp_q) begin
                nack_flag_q <= 1'b1;
                state_q     <= ST_STOP;
              end
`ifdef IIC_READ_EN
              else if (rw_q == RW_READ) begin
                state_q <= ST_RSTART;
              end
`endif
              else begin
                state_q <= ST_WDATA;
                shreg_q <= wdata_q;
              end
            end
            ST_ACK_DATA: begin
              nack_flag_q <= sda_smp_q;
              state_q     <= ST_STOP;
            end
`ifdef IIC_READ_EN
            ST_RSTART: begin
              state_q <= ST_DEV_R;
              shreg_q <= dev_byte(dev_q, RW_READ);
            end
            ST_ACK_DEVR: begin
              if (sda_smp_q) begin
                nack_flag_q <= 1'b1;
                state_q     <= ST_STOP;
              end else begin
                state_q <= ST_RDATA;
              end
            end
            ST_MNACK: state_q <= ST_STOP;
`endif
            ST_STOP: begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              nack_q  <= nack_flag_q;
              sck_q   <= 1'b1;
            end
            default: state_q <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign nack = nack_q;
  assign sck  = sck_q;
  assign sda  = sda_oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_iic_mem_master.sv
// tb/tb_iic_mem_master.sv - self-checking bench with a bus-level memory responder
// Expectations follow IIC_READ_EN the same way the design does.
module tb_iic_mem_master;
  import iic_pkg::*;

  localparam int CLK_DIV = 4;
`ifdef IIC_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif
  localparam int EV_S = 'h100;
  localparam int EV_P = 'h101;
  localparam int EV_MACK = 'h200;

  logic       GCLK = 1'b0;
  logic       RESET;
  logic       start, rw;
  logic [6:0] dev_addr;
  logic [7:0] mem_addr, wdata;
  logic       busy, done, nack, sck;
  logic [7:0] rdata;
  wire        sda;
  logic       resp_oe = 1'b0;

  pullup (sda);
  assign sda = resp_oe ? 1'b0 : 1'bz;

  always #5 GCLK = ~GCLK;

  iic_mem_master #(.CLK_DIV(CLK_DIV)) dut (
    .GCLK(GCLK), .RESET(RESET), .start(start), .rw(rw), .dev_addr(dev_addr),
    .mem_addr(mem_addr), .wdata(wdata), .busy(busy), .done(done), .nack(nack),
    .rdata(rdata), .sck(sck), .sda(sda)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Responder: an IIC byte memory watching the bus and answering on SCL falls.
  logic [7:0] mem [256];
  bit         resp_present = 1'b1;
  logic [6:0] resp_dev = 7'h50;
  int         mon_q[$];
  int         viol = 0;
  int         phase = 0, nbits = 0, byte_no = 0;
  logic [7:0] sh = '0, ptr = '0;
  bit         ack = 0, rd_mode = 0, addressed = 0;
  logic       sck_p = 1'b1, sda_p = 1'b1;

  always @(negedge GCLK) begin : responder
    logic k, s;
    k = sck;
    s = (sda === 1'b0) ? 1'b0 : 1'b1;
    if (RESET) begin
      phase = 0; resp_oe = 1'b0; sck_p = 1'b1; sda_p = 1'b1;
    end else begin
      if ((k != sck_p) && (s != sda_p)) viol++;
      if (sck_p && k && sda_p && !s) begin
        mon_q.push_back(EV_S); phase = 1; nbits = 0; byte_no = 0; resp_oe = 1'b0;
      end else if (sck_p && k && !sda_p && s) begin
        mon_q.push_back(EV_P); phase = 0; resp_oe = 1'b0;
      end else if (!sck_p && k) begin
        if (phase == 1) begin
          sh = {sh[6:0], s}; nbits++;
          if (nbits == 8) begin
            mon_q.push_back(int'(sh));
            if (byte_no == 0) begin
              addressed = resp_present && (sh[7:1] == resp_dev);
              rd_mode = sh[0]; ack = addressed;
            end else begin
              ack = addressed && !rd_mode;
              if (byte_no == 1) ptr = sh;
              else if (byte_no == 2 && addressed) mem[ptr] = sh;
            end
            byte_no++; phase = 2;
          end
        end else if (phase == 3) begin
          nbits++;
          if (nbits == 8) phase = 4;
        end else if (phase == 4) begin
          mon_q.push_back(EV_MACK | int'(s)); phase = 0;
        end
      end else if (sck_p && !k) begin
        if (phase == 2) begin
          resp_oe = ack; phase = 5;
        end else if (phase == 5) begin
          resp_oe = 1'b0; nbits = 0;
          if (rd_mode && addressed && byte_no == 1) begin
            sh = mem[ptr]; resp_oe = !sh[7]; phase = 3;
          end else phase = 1;
        end else if (phase == 3) begin
          resp_oe = !sh[3'(7 - nbits)];
        end else if (phase == 4) begin
          resp_oe = 1'b0;
        end
      end
      sck_p = k; sda_p = s;
    end
  end

  logic [7:0] exp_rdata = 8'h00;

  task automatic run_txn(input bit rw_in, input logic [6:0] dev_in, input logic [7:0] addr_in,
                         input logic [7:0] wd_in, input int poke_cyc, input int rst_cyc);
    bit   eff_rd, acked, busy_bad, busy_at_done, nack_at_done;
    int   slots, exp_cyc, cyc, done_cyc, extra;
    int   exp_q[$];
    logic [7:0] rd_at_done;
    eff_rd  = rw_in && READ_EN;
    acked   = resp_present && (dev_in == resp_dev);
    slots   = !acked ? 11 : (eff_rd ? READ_SLOTS : WRITE_SLOTS);
    exp_cyc = 1 + slots * QUARTERS * CLK_DIV;
    exp_q.push_back(EV_S);
    exp_q.push_back(int'({dev_in, 1'b0}));
    if (acked) begin
      exp_q.push_back(int'(addr_in));
      if (eff_rd) begin
        exp_q.push_back(EV_S);
        exp_q.push_back(int'({dev_in, 1'b1}));
        exp_q.push_back(EV_MACK | 1);
        exp_rdata = mem[addr_in];
      end else exp_q.push_back(int'(wd_in));
    end
    exp_q.push_back(EV_P);

    @(negedge GCLK);
    mon_q.delete();
    rw = rw_in; dev_addr = dev_in; mem_addr = addr_in; wdata = wd_in; start = 1'b1;
    @(posedge GCLK);
    #1 start = 1'b0;
    cyc = 0; done_cyc = 0; busy_bad = 0; busy_at_done = 1; nack_at_done = 0; rd_at_done = 0;
    while (done_cyc == 0 && cyc < exp_cyc + 64) begin
      @(negedge GCLK);
      cyc++;
      start = (cyc == poke_cyc);
      if (rst_cyc != 0 && cyc == rst_cyc) begin
        #2 RESET = 1'b1;
        #1;
        check_eq("rst_sck", sck, 1'b1);
        check_eq("rst_sda", sda, 1'b1);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_rdata", rdata, 8'h00);
        exp_rdata = 8'h00;
        repeat (3) @(negedge GCLK);
        RESET = 1'b0;
        return;
      end
      if (done) begin
        done_cyc = cyc; busy_at_done = busy; nack_at_done = nack; rd_at_done = rdata;
      end else if (!busy) busy_bad = 1;
    end
    check_eq("done_cyc", done_cyc, exp_cyc);
    check_eq("busy_during", busy_bad, 1'b0);
    check_eq("busy_at_done", busy_at_done, 1'b0);
    check_eq("nack", nack_at_done, !acked);
    check_eq("rdata", rd_at_done, exp_rdata);
    extra = 0;
    repeat (48) begin
      @(negedge GCLK);
      if (done) extra++;
    end
    check_eq("extra_done", extra, 0);
    check_eq("idle_sck", sck, 1'b1);
    check_eq("idle_sda", sda, 1'b1);
    check_eq("stream_len", mon_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
      check_eq($sformatf("stream%0d", i), mon_q[i], exp_q[i]);
    if (acked && !eff_rd) check_eq("mem_wr", mem[addr_in], wd_in);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] d;
    logic [7:0] a;
    RESET = 1'b1; start = 1'b0; rw = 1'b0; dev_addr = '0; mem_addr = '0; wdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (4) @(negedge GCLK);
    check_eq("reset_sck", sck, 1'b1);
    check_eq("reset_sda", sda, 1'b1);
    check_eq("reset_busy", busy, 1'b0);
    check_eq("reset_done", done, 1'b0);
    check_eq("reset_nack", nack, 1'b0);
    check_eq("reset_rdata", rdata, 8'h00);
    RESET = 1'b0;
    @(negedge GCLK);

    run_txn(1'b0, 7'h50, 8'h12, 8'hA5, 0, 0);
    mem[8'h34] = 8'h3C;
    run_txn(1'b1, 7'h50, 8'h34, 8'h00, 0, 0);
    resp_present = 1'b0;
    run_txn(1'b0, 7'h50, 8'h77, 8'h11, 0, 0);
    resp_present = 1'b1;
    run_txn(1'b0, 7'h50, 8'h20, 8'h5A, 100, 0);
    run_txn(1'b0, 7'h50, 8'h21, 8'hC3, 0, 200);
    run_txn(1'b0, 7'h50, 8'h22, 8'h3E, 0, 0);
    run_txn(1'b1, 7'h50, 8'h34, 8'h99, 0, 0);

    for (int n = 0; n < 8; n++) begin
      d = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h50;
      a = 8'($urandom);
      mem[a] = 8'($urandom);
      run_txn(1'($urandom), d, a, 8'($urandom), 0, 0);
    end

    check_eq("sck_sda_same_cycle", viol, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/iic_mem_master.md
# iic_mem_master

IIC initiator that loads and reads back the coordinator's IRAM/DRAM images over the two-wire load interface (sck/sda). One instance per bus drives the same protocol the memory responders answer: single-byte write (S, dev+W, addr, data, P) or single-byte read (S, dev+W, addr, Sr, dev+R, data, NACK, P). It sits on the board-side test/loader path and lets the FPGA self-load or verify memory without an external host.

## Interface
- CLK_DIV, 4: GCLK cycles per SCL quarter-period; SCL period = 4*CLK_DIV cycles; legal range 2..255.
- GCLK  input  1  system clock; all logic on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- rw  input  1  0 = write, 1 = read; captured with start.
- dev_addr  input  7  responder address; captured with start.
- mem_addr  input  8  memory byte address; captured with start.
- wdata  input  8  write byte; captured with start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse at transaction end.
- nack  output  1  valid with done; 1 = a responder ACK slot read high.
- rdata  output  8  read byte; updated only on a successful read's done.
- sck  output  1  SCL, push-pull.
- sda  inout  1  SDA, open-drain: drives 0 or Z, samples pad.

## Operation
- Reset: sck=1, sda=Z, busy=0, done=0, nack=0, rdata=0x00, state IDLE.
- Every bit slot = 4 quarters: Q0 sck=0 and SDA updated; Q1 sck=0; Q2 sck=1, SDA sampled on last cycle of Q2; Q3 sck=1.
- START slot: SDA released in Q0–Q1, pulled low in Q3 while sck=1. Sr identical. STOP slot: SDA low in Q0–Q1, released in Q3 while sck=1.
- States: IDLE -> START -> DEV_W -> ACK_DEV -> ADDR -> ACK_ADDR -> (rw=0) WDATA -> ACK_DATA -> STOP -> IDLE; (rw=1) RSTART -> DEV_R -> ACK_DEVR -> RDATA -> MNACK -> STOP -> IDLE.
- Byte slots shift MSB first; dev byte = {dev_addr, rw_bit}; SDA released during every ACK slot and RDATA; MNACK releases SDA (logic 1).
- Any ACK slot sampling 1: skip to STOP, nack=1 at done; rdata unchanged.
- start while busy=1 ignored; no queueing.
- Bit counter 3 bits, wraps 7->0 into ACK slot; quarter counter 2 bits; divider counts 0..CLK_DIV-1.

## Timing
- start accepted in cycle 0; busy=1 from cycle 1.
- Write: 29 slots (1+9+9+9+1); done pulses at cycle 1 + 29*4*CLK_DIV (465 with CLK_DIV=4); busy falls same cycle.
- Read: 39 slots (1+9+9+1+9+9+1); done at cycle 1 + 39*4*CLK_DIV (625 with CLK_DIV=4).
- Aborted transaction: done at end of the STOP slot following the failing ACK slot.
- RESET mid-transaction: outputs to reset values asynchronously; no STOP is generated; next start begins a fresh START.
- sck/sda never change in the same cycle; SDA changes only while sck=0 except in START/Sr/STOP.

## Configuration
- IIC_READ_EN defined: read path (RSTART..MNACK, rdata register) compiled in.
- Undefined: rw ignored, all transactions are writes, rdata tied to 0x00, read states absent.

## Structure
- Package iic_pkg: state enum, QUARTERS=4, BITS_PER_BYTE=8, RW_WRITE/RW_READ constants, slot-count constants 29 and 39.
- Sub-module iic_bit_timer: divider + quarter counter, outputs quarter index and end-of-quarter/end-of-slot strobes.

## Test plan
- Write dev=0x50, addr=0x12, data=0xA5, responder ACKs all -> bit stream 0xA0, 0x12, 0xA5, STOP; done at cycle 465, nack=0.
- Read dev=0x50, addr=0x34, responder returns 0x3C -> stream 0xA0, 0x34, Sr, 0xA1, master NACK, STOP; rdata=0x3C at done, cycle 625.
- No responder (SDA pulled high) on write -> STOP after ACK_DEV, done with nack=1 at cycle 1+11*16=177.
- start pulsed again at cycle 100 during write -> ignored, single transaction, one done.
- RESET asserted at cycle 200 -> sck=1, sda=Z, busy=0 immediately; new write completes normally afterward.
- Build without IIC_READ_EN, rw=1 -> performs write of wdata, rdata stays 0x00.
